// File: rtl/bit_serializer.sv
// bit_serializer: accepts a parallel word over valid/ready and shifts it out one bit per cycle.
// Define SER_PARITY_EN to append an even-parity bit (extra PARITY state) to every frame.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_e;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             last_data;
  logic             frame_end;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  // Handshake: a word is taken at a rising edge where load_valid && load_ready.
  // load_ready is high in IDLE and in the final bit cycle of a frame, never during rst.
  assign last_data = (state_q == SHIFT) && (cnt_q == LAST_IDX);
`ifdef SER_PARITY_EN
  assign frame_end = (state_q == PARITY);
`else
  assign frame_end = last_data;
`endif
  assign load_ready = !rst && ((state_q == IDLE) || frame_end);
  assign accept     = load_valid && load_ready;
  assign shifted    = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
  assign busy       = (state_q != IDLE);
  assign word_done  = frame_end;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
`ifdef SER_PARITY_EN
    parity_d  = parity_q;
`endif
    ser_out   = 1'b0;
    ser_valid = 1'b0;

    case (state_q)
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
        shift_d   = shifted;
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_data) begin
          cnt_d = '0;
`ifdef SER_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_out   = parity_q;
        state_d   = IDLE;
      end
`endif
      default: ;
    endcase

    // A new word overrides the return to IDLE, giving back-to-back frames.
    if (accept) begin
      state_d  = SHIFT;
      shift_d  = load_data;
      cnt_d    = '0;
`ifdef SER_PARITY_EN
      parity_d = ^load_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
`ifdef SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one stimulus stream and
// are compared every cycle against a queue-of-bits model, plus table-driven directed frames.
module tb_bit_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FL     = W + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FL     = W;
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic m_load_ready, m_ser_out, m_ser_valid, m_word_done, m_busy;
  logic l_load_ready, l_ser_out, l_ser_valid, l_word_done, l_busy;

  bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(m_load_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .word_done(m_word_done), .busy(m_busy)
  );

  bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(l_load_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .word_done(l_word_done), .busy(l_busy)
  );

  always #5 clk = ~clk;

  // Each entry is {lsb_first_bit, msb_first_bit}; the front is the bit on the wire this cycle.
  logic [1:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        acc_last = 1'b0;
  logic [31:0] rec_m = '0, rec_l = '0, rec_wd = '0;
  int          rec_n = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [7:0]   exp_m;
    logic [7:0]   exp_l;
    logic         par;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    for (int i = 0; i < FL; i++) begin
      if (i < W) exp_q.push_back({d[i], d[W-1-i]});
      else       exp_q.push_back({^d, ^d});
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, then advance the model at the rising edge.
  task automatic cycle();
    logic busy_e, last_e, rdy_e, bm_e, bl_e;
    @(negedge clk);
    busy_e = (exp_q.size() != 0);
    last_e = (exp_q.size() == 1);
    rdy_e  = !rst && (exp_q.size() <= 1);
    bm_e = 1'b0;
    bl_e = 1'b0;
    if (busy_e) begin
      bm_e = exp_q[0][0];
      bl_e = exp_q[0][1];
    end
    chk("m_ser_valid", m_ser_valid, busy_e);
    chk("m_ser_out", m_ser_out, bm_e);
    chk("m_word_done", m_word_done, last_e);
    chk("m_busy", m_busy, busy_e);
    chk("m_load_ready", m_load_ready, rdy_e);
    chk("l_ser_valid", l_ser_valid, busy_e);
    chk("l_ser_out", l_ser_out, bl_e);
    chk("l_word_done", l_word_done, last_e);
    chk("l_busy", l_busy, busy_e);
    chk("l_load_ready", l_load_ready, rdy_e);
    if (m_ser_valid) begin
      rec_m  = {rec_m[30:0], m_ser_out};
      rec_l  = {rec_l[30:0], l_ser_out};
      rec_wd = {rec_wd[30:0], m_word_done};
      rec_n++;
    end
    @(posedge clk);
    acc_last = load_valid && rdy_e;
    if (rst) exp_q.delete();
    else begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc_last) push_frame(load_data);
    end
    #1;
  endtask

  // Present a word and hold it until the model says it was taken; returns cycles spent.
  task automatic accept_word(input string name, input logic [W-1:0] d, output int n);
    load_valid = 1'b1;
    load_data  = d;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc_last && n < 50);
    chk({name, "_accept"}, acc_last, 1'b1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      cycle();
      g++;
    end
  endtask

  task automatic frame_test(input string name, input logic [W-1:0] d, input logic [7:0] em,
                            input logic [7:0] el, input logic par);
    int n0, n;
    logic [31:0] mask, xm, xl;
    wait_idle();
    n0 = rec_n;
    accept_word(name, d, n);
    load_valid = 1'b0;
    load_data  = W'($urandom);
    repeat (FL + 2) cycle();
    mask = (32'd1 << FL) - 32'd1;
    xm = PAR_EN ? {23'd0, em, par} : {24'd0, em};
    xl = PAR_EN ? {23'd0, el, par} : {24'd0, el};
    chk({name, "_count"}, rec_n - n0, FL);
    chk({name, "_msb_bits"}, rec_m & mask, xm);
    chk({name, "_lsb_bits"}, rec_l & mask, xl);
    chk({name, "_word_done"}, rec_wd & mask, 32'd1);
  endtask

  initial begin
    int n0, n, gap;
    logic [31:0] mask, xb;

    vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h01, 8'h01, 8'h80, 1'b1};
    vecs[2] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
    vecs[4] = '{8'hC1, 8'hC1, 8'h83, 1'b1};
    vecs[5] = '{8'h07, 8'h07, 8'hE0, 1'b1};

    // Reset with load_valid high: the word must not be taken.
    rst = 1'b1;
    load_valid = 1'b1;
    load_data = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    load_valid = 1'b0;
    cycle();

    for (int i = 0; i < 6; i++)
      frame_test($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_m, vecs[i].exp_l, vecs[i].par);

    // Back-to-back: A5 then 3C held on load_data.
    wait_idle();
    n0 = rec_n;
    accept_word("b2b_first", 8'hA5, n);
    accept_word("b2b_second", 8'h3C, gap);
    chk("b2b_gap", gap, FL);
    load_valid = 1'b0;
    repeat (2 * FL + 2) cycle();
    mask = (32'd1 << (2 * FL)) - 32'd1;
    xb = PAR_EN ? {14'd0, 8'hA5, 1'b0, 8'h3C, 1'b0} : {16'd0, 8'hA5, 8'h3C};
    chk("b2b_count", rec_n - n0, 2 * FL);
    chk("b2b_msb_bits", rec_m & mask, xb);
    chk("b2b_lsb_bits", rec_l & mask, xb);
    chk("b2b_word_done", rec_wd & mask, (32'd1 << FL) | 32'd1);

    // Reset on cycle 4 of a frame, with load_valid high alongside it.
    wait_idle();
    accept_word("rst_frame", 8'hC1, n);
    load_valid = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;
    load_valid = 1'b1;
    load_data = 8'h55;
    cycle();
    rst = 1'b0;
    load_valid = 1'b0;
    n0 = rec_n;
    repeat (3) cycle();
    chk("rst_no_bits", rec_n - n0, 0);
    frame_test("after_rst", 8'hFF, 8'hFF, 8'hFF, 1'b0);

    // Random traffic: valid toggling, data changing every cycle, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = W'($urandom);
      rst        = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    load_valid = 1'b0;
    wait_idle();
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits, legal range 2..16.
REQ-002 The block SHALL have parameter LSB_FIRST, default 0: 0 sends MSB first, 1 sends LSB first.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port load_valid, input, 1 bit: upstream holds a word on load_data.
REQ-006 The block SHALL have port load_data, input, WIDTH bits: parallel word to serialize.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port ser_out, output, 1 bit: serial bit stream to the downstream pattern detector input.
REQ-009 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a frame bit this cycle.
REQ-010 The block SHALL have port word_done, output, 1 bit: one-cycle pulse on the last bit of a frame.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE.

Function
REQ-012 A word SHALL be accepted at a rising edge where load_valid=1 and load_ready=1, and the accepted word SHALL be latched into an internal WIDTH-bit shift register.
REQ-013 The block SHALL have states IDLE, SHIFT, and PARITY (PARITY exists only with SER_PARITY_EN).
REQ-014 From IDLE, an accepted word SHALL move the block to SHIFT, and the first bit SHALL appear on ser_out with ser_valid=1 in the cycle after acceptance (latency 1).
REQ-015 In SHIFT, the block SHALL present exactly one bit per cycle for WIDTH cycles, MSB first when LSB_FIRST=0 and LSB first otherwise, with no gaps.
REQ-016 A bit counter (width ceil(log2(WIDTH+1))) SHALL count frame bits and SHALL never wrap within a frame.
REQ-017 load_ready SHALL be 1 in IDLE and in the last-bit cycle of a frame, and 0 in all other cycles and whenever rst=1.
REQ-018 If a word is accepted in the last-bit cycle, its first bit SHALL follow in the next cycle (back-to-back, ser_valid continuous), and the block SHALL stay in SHIFT.
REQ-019 If no word is accepted in the last-bit cycle, the block SHALL return to IDLE, and ser_valid and ser_out SHALL be 0 in IDLE.
REQ-020 word_done SHALL be 1 exactly in the last-bit cycle of each frame.
REQ-021 Changes on load_data or load_valid while load_ready=0 SHALL have no effect on the frame in progress.

Reset
REQ-022 When rst=1 at a rising edge, the block SHALL go to IDLE, clear the shift register and bit counter, and the next cycle SHALL show ser_out=0, ser_valid=0, word_done=0, and busy=0.
REQ-023 A reset mid-frame SHALL discard the partial word, with no further bits emitted and no word_done pulse.
REQ-024 load_valid asserted in the same cycle as rst=1 SHALL NOT be accepted.

Configuration
REQ-025 With macro SER_PARITY_EN defined, each frame SHALL append one even-parity bit (XOR of all WIDTH data bits) in state PARITY after the data bits, making the frame WIDTH+1 bits long.
REQ-026 With SER_PARITY_EN defined, the parity cycle SHALL be the last-bit cycle for REQ-017, REQ-018 and REQ-020.
REQ-027 With SER_PARITY_EN undefined, the PARITY state and parity logic SHALL be absent, and the frame SHALL be WIDTH bits long.

Verification
REQ-028 The bench SHALL check: WIDTH=8, LSB_FIRST=0, load 8'hA5 from IDLE -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance, word_done only on cycle 8, then IDLE.
REQ-029 The bench SHALL check: load 8'hA5 then hold load_valid with 8'h3C -> 16 consecutive ser_valid cycles 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, with word_done on cycles 8 and 16.
REQ-030 The bench SHALL check: LSB_FIRST=1, load 8'h01 -> ser_out 1 then seven 0s.
REQ-031 The bench SHALL check: rst=1 on cycle 4 of a frame -> the next cycle has ser_valid=0 and busy=0 with no word_done, and a subsequent load of 8'hFF serializes cleanly.
REQ-032 The bench SHALL check: with SER_PARITY_EN, load 8'hA5 -> 9-bit frame ending in parity 0; load 8'h07 -> frame ending in parity 1; word_done on bit 9 only.
REQ-033 The bench SHALL check: with load_valid=1 continuously and load_data changing every cycle mid-frame -> only words sampled in load_ready cycles appear on ser_out.
